// File: rtl/sram_access_controller.sv
// sram_access_controller
//   Sequences an external 16-bit SRAM for 32-bit MEM-stage loads and stores.
//   Each access is split into a low and a high halfword phase, each holding
//   address/control for WAIT_CYCLES cycles. `ready` drops while an access is
//   in flight so the pipeline can freeze on ~ready.
//
// Parameters
//   WAIT_CYCLES  cycles per halfword phase (>= 1)
//   BASE_ADDR    data-memory base byte address
//   SRAM_AW      SRAM halfword address width
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   rd_en, wr_en  load / store request (store wins when both are set)
//   address       byte address of the access
//   write_data    store data
//   read_data     load data, updated when a read completes
//   ready         1 = idle or completing, 0 = freeze pipeline
//   sram_addr     halfword address to SRAM
//   sram_dq_out   write halfword, sram_dq_in read halfword
//   sram_dq_oe    1 = controller drives the SRAM data bus
//   sram_we_n     active-low SRAM write enable
//   addr_err      (SRAM_ACCESS_CTRL_RANGE_CHECK_EN only) pulses in the
//                 completion cycle of a rejected request
//
// Optional feature macro: SRAM_ACCESS_CTRL_RANGE_CHECK_EN
//   Rejects misaligned / out-of-window requests without touching the SRAM.
//   Without it, out-of-range addresses wrap modulo the SRAM size.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight, SRAM idle, accepts a new request
// RD_LO | low halfword read phase, samples dq_in on its last cycle
// RD_HI | high halfword read phase, updates read_data on its last cycle
// WR_LO | low halfword write phase, drives write_data[15:0]
// WR_HI | high halfword write phase, drives write_data[31:16]
// DONE  | completion cycle, ready=1, always returns to IDLE

module sram_access_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef SRAM_ACCESS_CTRL_RANGE_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic               last;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] lo_addr;
  logic [15:0]        wr_hi_q;
  logic [15:0]        rd_lo_q;
  logic               req;
  logic               range_err;
  logic               accept_wr;
  logic               accept_rd;
  logic               unused_offset;

  assign last    = (cnt == CW'(WAIT_CYCLES - 1));
  assign req     = rd_en | wr_en;
  // Word index is (address - base) >> 2; its low SRAM_AW-1 bits form the
  // even halfword address, so wrap-around falls out of the truncation.
  assign offset  = address - 32'(BASE_ADDR);
  assign lo_addr = {offset[SRAM_AW:2], 1'b0};
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

`ifdef SRAM_ACCESS_CTRL_RANGE_CHECK_EN
  localparam logic [31:0] WORD_LIMIT = 32'(1) << (SRAM_AW - 1);

  assign range_err = (address < 32'(BASE_ADDR)) ||
                     ({2'b00, offset[31:2]} >= WORD_LIMIT) ||
                     (address[1:0] != 2'b00);

  // Registered on the IDLE->DONE transition, so it is high only in DONE.
  always_ff @(posedge clk) begin
    if (rst) addr_err <= 1'b0;
    else     addr_err <= (state == IDLE) && req && range_err;
  end
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          if (range_err) begin
            state_next = DONE;
          end else if (wr_en) begin
            state_next = WR_LO;
            accept_wr  = 1'b1;
          end else begin
            state_next = RD_LO;
            accept_rd  = 1'b1;
          end
        end
      end
      RD_LO:   if (last) state_next = RD_HI;
      RD_HI:   if (last) state_next = DONE;
      WR_LO:   if (last) state_next = WR_HI;
      WR_HI:   if (last) state_next = DONE;
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered so they switch exactly at phase boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      wr_hi_q     <= '0;
      rd_lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept_wr) begin
            sram_addr   <= lo_addr;
            sram_dq_out <= write_data[15:0];
            wr_hi_q     <= write_data[31:16];
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= 1'b0;
          end else if (accept_rd) begin
            sram_addr <= lo_addr;
          end
        end
        RD_LO: begin
          if (last) begin
            cnt       <= '0;
            rd_lo_q   <= sram_dq_in;
            sram_addr <= {sram_addr[SRAM_AW-1:1], 1'b1};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_HI: begin
          if (last) begin
            cnt       <= '0;
            read_data <= {sram_dq_in, rd_lo_q};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_LO: begin
          if (last) begin
            cnt         <= '0;
            sram_dq_out <= wr_hi_q;
            sram_addr   <= {sram_addr[SRAM_AW-1:1], 1'b1};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR_HI: begin
          if (last) begin
            cnt        <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
